// File: rtl/sram_ctrl_pkg.sv
// Shared types for the 16-bit asynchronous SRAM sequencer.
// The state enum is exported so benches and debug logic can decode the FSM.
package sram_ctrl_pkg;

    localparam int HALF_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } state_t;

endpackage

// File: rtl/sram_ctrl.sv
// Splits a 32-bit request into two half-word cycles on an asynchronous SRAM,
// low half first, with setup / wait-stated strobe / hold phases per half.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 18,
    parameter int WAIT_CYC = 2
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    // Requester handshake: s_access is a level held high until the requester
    // samples sram_wr_finish; the request fields are captured once at the end
    // of LATCH and ignored afterwards, so no back-pressure path exists.
    input  logic              s_access,
    input  logic              s_we,
    input  logic [31:0]       s_addr,
    input  logic [31:0]       s_wdata,
    output logic [31:0]       s_rdata,
    output logic              sram_wr_finish,
    output logic              busy,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [HALF_W-1:0] sram_dq_o,
    input  logic [HALF_W-1:0] sram_dq_i,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_lb_n,
    output logic              sram_ub_n,
    output state_t            dbg_state
);

    localparam int CNT_W = $clog2(WAIT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYC - 1);

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-2:0]   addr_q;
    logic                we_q;
    logic [HALF_W-1:0]   wdata_hi;
    logic                half;
    logic [CNT_W-1:0]    cnt;
    logic [31:0]         rbuf;
    logic                cycle_active;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^{s_addr[31:ADDR_W+1], s_addr[1:0]};

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (s_access) state_next = LATCH;
            LATCH:   state_next = SETUP;
            SETUP:   state_next = STROBE;
            STROBE:  if (cnt == '0) state_next = HOLD;
            HOLD:    state_next = half ? DONE : SETUP;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_hi  <= '0;
            half      <= 1'b0;
            cnt       <= '0;
            rbuf      <= '0;
            s_rdata   <= '0;
            sram_addr <= '0;
            sram_dq_o <= '0;
        end else begin
            case (state)
                LATCH: begin
                    // The low half goes straight to the pad registers so
                    // SETUP already presents a stable address and data.
                    addr_q    <= s_addr[ADDR_W:2];
                    we_q      <= s_we;
                    wdata_hi  <= s_wdata[31:16];
                    half      <= 1'b0;
                    sram_addr <= {s_addr[ADDR_W:2], 1'b0};
                    if (s_we) sram_dq_o <= s_wdata[15:0];
                end
                SETUP: cnt <= CNT_LOAD;
                STROBE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (!we_q) begin
                        if (half) rbuf[31:16] <= sram_dq_i;
                        else      rbuf[15:0]  <= sram_dq_i;
                    end
                end
                HOLD: begin
                    if (!half) begin
                        half      <= 1'b1;
                        sram_addr <= {addr_q, 1'b1};
                        if (we_q) sram_dq_o <= wdata_hi;
                    end else if (!we_q) begin
                        s_rdata <= rbuf;
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes decode straight from the state register so a synchronous reset
    // drops them on the very next edge.
    assign cycle_active   = (state == SETUP) || (state == STROBE) || (state == HOLD);
    assign sram_ce_n      = ~cycle_active;
    assign sram_lb_n      = ~cycle_active;
    assign sram_ub_n      = ~cycle_active;
    assign sram_we_n      = ~((state == STROBE) && we_q);
    assign sram_oe_n      = ~((state == STROBE) && !we_q);
    assign sram_dq_oe     = cycle_active && we_q;
    assign sram_wr_finish = (state == DONE);
    assign busy           = (state != IDLE);
    assign dbg_state      = state;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: three instances cover WAIT_CYC = 2, 1 and 5;
// instance 0 is backed by a small behavioural SRAM.
module tb_sram_ctrl;
    import sram_ctrl_pkg::*;

    logic               clk = 1'b0;
    logic               RST_I;
    logic [2:0]         acc;
    logic               s_we;
    logic [31:0]        s_addr;
    logic [31:0]        s_wdata;

    logic [2:0][31:0]   rdata_a;
    logic [2:0]         fin_a, busy_a, dq_oe_a, ce_n_a, oe_n_a, we_n_a, lb_n_a, ub_n_a;
    logic [2:0][17:0]   addr_a;
    logic [2:0][15:0]   dqo_a;
    logic [15:0]        dqi0;
    state_t             st0, st1, st2;

    logic [15:0]        mem [64];

    int n_assert = 0;
    int n_fail   = 0;

    int          fin_cyc, fin_cnt, post_busy, oe_cnt, addr_var;
    int          we_lo [2];
    int          oe_lo [2];
    logic [17:0] strobe_addr [2];
    logic [15:0] strobe_dq [2];
    logic [31:0] rdata_fin;
    logic        rst_we_n, rst_ce_n, rst_busy, rst_fin;

    always #5 clk = ~clk;

    sram_ctrl #(.ADDR_W(18), .WAIT_CYC(2)) dut0 (
        .CLK_I(clk), .RST_I(RST_I), .s_access(acc[0]), .s_we(s_we), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_rdata(rdata_a[0]), .sram_wr_finish(fin_a[0]), .busy(busy_a[0]),
        .sram_addr(addr_a[0]), .sram_dq_o(dqo_a[0]), .sram_dq_i(dqi0), .sram_dq_oe(dq_oe_a[0]),
        .sram_ce_n(ce_n_a[0]), .sram_oe_n(oe_n_a[0]), .sram_we_n(we_n_a[0]),
        .sram_lb_n(lb_n_a[0]), .sram_ub_n(ub_n_a[0]), .dbg_state(st0)
    );

    sram_ctrl #(.ADDR_W(18), .WAIT_CYC(1)) dut1 (
        .CLK_I(clk), .RST_I(RST_I), .s_access(acc[1]), .s_we(s_we), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_rdata(rdata_a[1]), .sram_wr_finish(fin_a[1]), .busy(busy_a[1]),
        .sram_addr(addr_a[1]), .sram_dq_o(dqo_a[1]), .sram_dq_i(16'h0000), .sram_dq_oe(dq_oe_a[1]),
        .sram_ce_n(ce_n_a[1]), .sram_oe_n(oe_n_a[1]), .sram_we_n(we_n_a[1]),
        .sram_lb_n(lb_n_a[1]), .sram_ub_n(ub_n_a[1]), .dbg_state(st1)
    );

    sram_ctrl #(.ADDR_W(18), .WAIT_CYC(5)) dut2 (
        .CLK_I(clk), .RST_I(RST_I), .s_access(acc[2]), .s_we(s_we), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_rdata(rdata_a[2]), .sram_wr_finish(fin_a[2]), .busy(busy_a[2]),
        .sram_addr(addr_a[2]), .sram_dq_o(dqo_a[2]), .sram_dq_i(16'h0000), .sram_dq_oe(dq_oe_a[2]),
        .sram_ce_n(ce_n_a[2]), .sram_oe_n(oe_n_a[2]), .sram_we_n(we_n_a[2]),
        .sram_lb_n(lb_n_a[2]), .sram_ub_n(ub_n_a[2]), .dbg_state(st2)
    );

    // Behavioural SRAM for instance 0, indexed by the low address bits.
    assign dqi0 = (!ce_n_a[0] && !oe_n_a[0]) ? mem[addr_a[0][5:0]] : 16'h0000;

    always @(posedge clk) begin
        if (!ce_n_a[0] && !we_n_a[0]) mem[addr_a[0][5:0]] <= dqo_a[0];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one request on instance sel and records per-cycle observations.
    // Cycle 1 is the LATCH cycle following the edge that samples s_access.
    task automatic run_access(input int sel, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input int drop_cyc,
                              input int toggle_cyc, input int rst_cyc, input int tail);
        int   run;
        logic lo, prev_lo;
        fin_cyc = -1; fin_cnt = 0; post_busy = -1; oe_cnt = 0; addr_var = 0;
        we_lo[0] = 0; we_lo[1] = 0; oe_lo[0] = 0; oe_lo[1] = 0;
        strobe_addr[0] = '0; strobe_addr[1] = '0; strobe_dq[0] = '0; strobe_dq[1] = '0;
        rdata_fin = '0;
        run = -1;
        prev_lo = 1'b0;
        @(negedge clk);
        acc[sel] = 1'b1;
        s_we     = we;
        s_addr   = addr;
        s_wdata  = ~wdata;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 1) s_wdata = wdata;
            if (cyc == drop_cyc) acc[sel] = 1'b0;
            if (cyc == toggle_cyc) begin
                s_addr  = ~addr;
                s_we    = ~we;
                s_wdata = ~wdata;
            end
            if (rst_cyc > 0 && cyc == rst_cyc + 1) begin
                rst_we_n = we_n_a[sel];
                rst_ce_n = ce_n_a[sel];
                rst_busy = busy_a[sel];
                rst_fin  = fin_a[sel];
                RST_I    = 1'b0;
            end
            if (rst_cyc > 0 && cyc == rst_cyc) begin
                RST_I    = 1'b1;
                acc[sel] = 1'b0;
            end
            lo = !we_n_a[sel] || !oe_n_a[sel];
            if (lo && !prev_lo) begin
                run++;
                if (run < 2) begin
                    strobe_addr[run] = addr_a[sel];
                    strobe_dq[run]   = dqo_a[sel];
                end
            end
            if (lo && run >= 0 && run < 2) begin
                if (!we_n_a[sel]) we_lo[run]++;
                if (!oe_n_a[sel]) oe_lo[run]++;
                if (addr_a[sel] != strobe_addr[run]) addr_var++;
            end
            prev_lo = lo;
            if (dq_oe_a[sel]) oe_cnt++;
            if (fin_cyc > 0 && cyc == fin_cyc + 1) post_busy = int'(busy_a[sel]);
            if (fin_a[sel]) begin
                fin_cnt++;
                if (fin_cyc < 0) begin
                    fin_cyc   = cyc;
                    rdata_fin = rdata_a[sel];
                    acc[sel]  = 1'b0;
                end
            end
            if (fin_cyc > 0 && cyc >= fin_cyc + tail) break;
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
        RST_I = 1'b1; acc = 3'b000; s_we = 1'b0; s_addr = '0; s_wdata = '0;
        rst_we_n = 1'b0; rst_ce_n = 1'b0; rst_busy = 1'b1; rst_fin = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        RST_I = 1'b0;
        @(posedge clk);
        #1;
        check("rst_ctl_n", 32'({ce_n_a[0], oe_n_a[0], we_n_a[0], lb_n_a[0], ub_n_a[0]}), 32'h1f);
        check("rst_dq_oe", 32'(dq_oe_a[0]), 0);
        check("rst_busy", 32'(busy_a[0]), 0);
        check("rst_rdata", rdata_a[0], 0);
        check("rst_finish", 32'(fin_a[0]), 0);
        check("rst_addr", 32'(addr_a[0]), 0);
        check("rst_state", 32'(st0), 32'(IDLE));

        // Write 0xDEADBEEF to byte address 0x10: half-words 0x8 then 0x9.
        run_access(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0, 0, 3);
        check("wr_fin_cyc", fin_cyc, 10);
        check("wr_fin_cnt", fin_cnt, 1);
        check("wr_we_lo0", we_lo[0], 2);
        check("wr_we_lo1", we_lo[1], 2);
        check("wr_addr0", 32'(strobe_addr[0]), 32'h8);
        check("wr_addr1", 32'(strobe_addr[1]), 32'h9);
        check("wr_dq0", 32'(strobe_dq[0]), 32'hBEEF);
        check("wr_dq1", 32'(strobe_dq[1]), 32'hDEAD);
        check("wr_mem8", 32'(mem[8]), 32'hBEEF);
        check("wr_mem9", 32'(mem[9]), 32'hDEAD);
        check("wr_oe_cnt", oe_cnt, 8);
        check("wr_rdata_kept", rdata_a[0], 0);
        check("wr_post_busy", post_busy, 0);

        run_access(0, 1'b0, 32'h0000_0010, 32'h0, 0, 0, 0, 3);
        check("rd_fin_cyc", fin_cyc, 10);
        check("rd_rdata", rdata_fin, 32'hDEAD_BEEF);
        check("rd_oe_lo0", oe_lo[0], 2);
        check("rd_oe_lo1", oe_lo[1], 2);
        check("rd_we_lo0", we_lo[0], 0);
        check("rd_dq_oe", oe_cnt, 0);

        // s_access dropped during the first strobe cycle.
        run_access(0, 1'b1, 32'h0000_0024, 32'h1234_5678, 3, 0, 0, 4);
        check("drop_fin_cyc", fin_cyc, 10);
        check("drop_fin_cnt", fin_cnt, 1);
        check("drop_mem12", 32'(mem[6'h12]), 32'h5678);
        check("drop_mem13", 32'(mem[6'h13]), 32'h1234);

        // Request fields flipped (including s_we) during STROBE.
        run_access(0, 1'b0, 32'h0000_0024, 32'h0, 0, 3, 0, 3);
        check("tog_addr0", 32'(strobe_addr[0]), 32'h12);
        check("tog_addr1", 32'(strobe_addr[1]), 32'h13);
        check("tog_addr_var", addr_var, 0);
        check("tog_dq_oe", oe_cnt, 0);
        check("tog_oe_lo1", oe_lo[1], 2);
        check("tog_rdata", rdata_fin, 32'h1234_5678);

        run_access(1, 1'b1, 32'h0000_0040, 32'hA5A5_5A5A, 0, 0, 0, 3);
        check("w1_fin_cyc", fin_cyc, 8);
        check("w1_we_lo0", we_lo[0], 1);
        check("w1_we_lo1", we_lo[1], 1);
        check("w1_addr1", 32'(strobe_addr[1]), 32'h21);

        run_access(2, 1'b1, 32'h0000_0044, 32'h0F0F_F0F0, 0, 0, 0, 3);
        check("w5_fin_cyc", fin_cyc, 16);
        check("w5_we_lo0", we_lo[0], 5);
        check("w5_we_lo1", we_lo[1], 5);
        check("w5_dq1", 32'(strobe_dq[1]), 32'h0F0F);

        // Back-to-back: the next request is raised in the single IDLE cycle.
        run_access(0, 1'b1, 32'h0000_0030, 32'h0BAD_F00D, 0, 0, 0, 1);
        check("b2b_a_fin_cyc", fin_cyc, 10);
        check("b2b_a_idle", post_busy, 0);
        run_access(0, 1'b1, 32'h0000_0034, 32'hCAFE_1234, 0, 0, 0, 3);
        check("b2b_b_fin_cyc", fin_cyc, 10);
        check("b2b_b_fin_cnt", fin_cnt, 1);
        check("b2b_mem19", 32'(mem[6'h19]), 32'h0BAD);
        check("b2b_mem1a", 32'(mem[6'h1a]), 32'h1234);

        // Reset asserted in the first high-half strobe cycle.
        run_access(0, 1'b1, 32'h0000_0050, 32'h7777_8888, 0, 0, 7, 3);
        check("rstw_we_n", 32'(rst_we_n), 1);
        check("rstw_ce_n", 32'(rst_ce_n), 1);
        check("rstw_busy", 32'(rst_busy), 0);
        check("rstw_fin", 32'(rst_fin), 0);
        check("rstw_fin_cnt", fin_cnt, 0);
        check("rstw_rdata", rdata_a[0], 0);
        check("rstw_state", 32'(st0), 32'(IDLE));
        check("rstw_idle_w1", 32'(st1), 32'(IDLE));
        check("rstw_idle_w5", 32'(st2), 32'(IDLE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Sequencer for an external 16-bit asynchronous SRAM, placed behind the Wishbone slave front end. It accepts a 32-bit request on the `s_*` side and performs two half-word SRAM cycles, low half first. Setup, strobe and hold phases are generated under a programmable wait-state count. Completion of reads and writes is reported with a single `sram_wr_finish` pulse.

## Interface
- `ADDR_W`, 18: SRAM half-word address width.
- `WAIT_CYC`, 2: strobe-phase length in cycles per half-word; legal range is ≥1.
- `CLK_I` input 1: single clock, rising edge.
- `RST_I` input 1: reset, synchronous, active-high.
- `s_access` input 1: level request. Held high by the requester until it samples `sram_wr_finish`.
- `s_we` input 1: 1 = write, 0 = read.
- `s_addr` input 32: byte address. Bits [ADDR_W:2] select the 32-bit word; all other bits are ignored.
- `s_wdata` input 32: write data.
- `s_rdata` output 32: read data, registered.
- `sram_wr_finish` output 1: one-cycle completion pulse, for both reads and writes.
- `busy` output 1: high whenever the FSM is not in IDLE.
- `sram_addr` output ADDR_W: half-word address, equal to {latched s_addr[ADDR_W:2], half}.
- `sram_dq_o` output 16: write data to the pad.
- `sram_dq_i` input 16: read data from the pad.
- `sram_dq_oe` output 1: pad output enable.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`, `sram_lb_n`, `sram_ub_n` output 1 each: active-low SRAM controls.

## Operation
- **States**:
  - IDLE, LATCH, SETUP, STROBE, HOLD, DONE.
  - A 1-bit `half` register selects the half-word: 0 = bits [15:0] at the even address, 1 = bits [31:16].
- **IDLE**
  - `s_access`=1 → LATCH; otherwise remain in IDLE.
- **LATCH**
  - Lasts one cycle, to absorb a one-cycle skew between `s_access` and `s_wdata` on the requester side.
  - On exit, capture `s_addr`, `s_we` and `s_wdata` into internal registers, clear `half`, → SETUP.
- **SETUP**
  - Lasts one cycle.
  - `sram_addr` valid, `ce_n`=0, `lb_n`=`ub_n`=0.
  - Write: `dq_oe`=1 and `sram_dq_o`=selected half of latched wdata.
  - Load the wait counter with WAIT_CYC−1, → STROBE.
- **STROBE**
  - Write: `we_n`=0. Read: `oe_n`=0.
  - Counter decrements each cycle; at 0 → HOLD.
  - Read: on the edge leaving STROBE, capture `sram_dq_i` into the selected half of an internal read buffer.
- **HOLD**
  - Lasts one cycle.
  - `we_n`=`oe_n`=1; `ce_n`, address and (write) `dq_o`/`dq_oe` held.
  - `half`=0 → set `half`=1, → SETUP.
  - `half`=1 → DONE.
- **DONE**
  - Lasts one cycle; `sram_wr_finish`=1.
  - All SRAM controls inactive, `dq_oe`=0.
  - Read: `s_rdata` is loaded from the read buffer on entry to DONE and holds until the next read completes. Writes never alter `s_rdata`.
  - → IDLE.
- **Outside SETUP/STROBE/HOLD**: `ce_n`, `oe_n`, `we_n`, `lb_n`, `ub_n` are all 1 and `dq_oe`=0. `sram_addr` and `sram_dq_o` keep their last value.
- **`dq_oe` on reads**: never asserted.
- **`s_access` deasserted mid-operation**: ignored; the access runs to completion and `sram_wr_finish` still pulses. No abort is supported.
- **New `s_access` while busy**: ignored. The requester drops `s_access` on the edge it samples the finish pulse, so IDLE sees 0 on the following cycle and no spurious re-trigger occurs.
- **`s_addr`/`s_we`/`s_wdata` changes after LATCH**: no effect on the access in progress.

## Timing
- **Reference edge**: edge E0 is the edge at which IDLE samples `s_access`=1. LATCH occupies cycle 1.
- **Per half-word**: 2+WAIT_CYC cycles.
- **Finish latency**: `sram_wr_finish` is high in cycle 2+2·(2+WAIT_CYC) after E0, which is cycle 10 for WAIT_CYC=2.
- **Throughput**: one request per 3+2·(2+WAIT_CYC) cycles, minimum.
- **Write signal margins**: `we_n` falls ≥1 cycle after the address and `dq` are stable. It rises 1 cycle before the address or `dq` change or `dq_oe` drops.
- **Reset**:
  - Reset values: state=IDLE, `half`=0, `busy`=0, `sram_wr_finish`=0, `s_rdata`=0, `sram_addr`=0, `sram_dq_o`=0, `dq_oe`=0, all *_n outputs = 1.
  - Reset mid-access: every strobe is deasserted on the next edge, no finish pulse is produced, and `s_rdata` is cleared.
- **Counter width**: $clog2(WAIT_CYC+1). The counter never underflows.

## Structure
- **Package `sram_ctrl_pkg`**: state enum (IDLE, LATCH, SETUP, STROBE, HOLD, DONE) and a `HALF_W`=16 constant.
- **Module split**: single module, no sub-module.
- **Pad tristate**: the `sram_dq` tristate (`dq_o`/`dq_i`/`dq_oe` → inout) is done at the chip top, not inside this block.

## Test plan
- **Reset**: hold `RST_I` 3 cycles, then release → all *_n=1, `dq_oe`=0, `busy`=0, `s_rdata`=0, no finish pulse.
- **Write**: `s_access` with `s_we`=1, `s_addr`=0x0000_0010, `s_wdata` presented one cycle late =0xDEAD_BEEF.
  - Expected SRAM cycles: addr 0x8 gets 0xBEEF, then addr 0x9 gets 0xDEAD.
  - `we_n` low for exactly 2 cycles per half.
  - Finish in cycle 10.
- **Read-back**: read 0x10, with the SRAM model returning the written data → `s_rdata`=0xDEAD_BEEF valid with the finish pulse.
  - `oe_n` low 2 cycles per half; `dq_oe` stays 0.
- **Wait states**: WAIT_CYC=1 and WAIT_CYC=5.
  - Finish in cycles 8 and 16 respectively.
  - Strobe widths of 1 and 5 cycles.
- **Protocol robustness**:
  - Drop `s_access` during STROBE → access completes and finish pulses once.
  - Toggle `s_addr` during STROBE → `sram_addr` stays unchanged.
  - Back-to-back requests → no overlap; IDLE lasts ≥1 cycle between them.
- **Reset mid-write**: assert `RST_I` during high-half STROBE → `we_n`=1 and `ce_n`=1 on the next edge, no finish pulse, `busy`=0.
